// File: rtl/packet_fifo.sv
// Packet-aware FIFO: words become readable only once their packet commits.
// Errored or oversized packets are discarded by rolling back the write pointer.
module packet_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrreq,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_eop,
    input  logic                  wr_error,
    input  logic                  rdreq,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_eop,
    output logic                  rdempty,
    output logic                  wrfull,
    output logic [ADDR_WIDTH:0]   rdusedw,
    output logic                  drop_pulse
);

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wstate_e;

    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic                  mem_we;

    wstate_e               state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   commit_ptr_q, commit_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_eop_q, rd_eop_d;
    logic                  drop_pulse_q, drop_pulse_d;

    logic                  empty_w;
    logic                  full_w;
    logic [DATA_WIDTH:0]   rd_entry;

    assign empty_w  = (rd_ptr_q == commit_ptr_q);
    assign full_w   = ((wr_ptr_q - rd_ptr_q) == FULL_LVL);
    assign rd_entry = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_pulse_d = 1'b0;
        mem_we       = 1'b0;
        unique case (state_q)
            ACCEPT: begin
                if (wr_error) begin
                    wr_ptr_d     = commit_ptr_q;
                    drop_pulse_d = 1'b1;
                end else if (wrreq && !full_w) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_eop) begin
                        commit_ptr_d = wr_ptr_q + 1'b1;
                    end
                end else if (wrreq) begin
                    // Packet cannot fit: discard what was stored so far
                    wr_ptr_d = commit_ptr_q;
                    if (wr_eop) begin
                        drop_pulse_d = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (wr_error || (wrreq && wr_eop)) begin
                    drop_pulse_d = 1'b1;
                    state_d      = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        rd_eop_d  = rd_eop_q;
        if (rdreq && !empty_w) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = rd_entry[DATA_WIDTH-1:0];
            rd_eop_d  = rd_entry[DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rd_data_q    <= '0;
            rd_eop_q     <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_data_q    <= rd_data_d;
            rd_eop_q     <= rd_eop_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {wr_eop, wr_data};
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_eop     = rd_eop_q;
    assign rdempty    = empty_w;
    assign wrfull     = full_w;
    assign rdusedw    = commit_ptr_q - rd_ptr_q;
    assign drop_pulse = drop_pulse_q;

endmodule
